// File: rtl/dmux1t8_32_buf.sv
// Buffered 1-to-8 demultiplexer for WIDTH-bit words.
// Each channel owns a data register and a valid flag; a word written into a
// channel is held until that channel's consumer acknowledges it. The target
// channel is either the explicit select or an internal round-robin pointer.
module dmux1t8_32_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       s,
    input  logic             auto,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [7:0]       o_valid,
    input  logic [7:0]       o_ack,
    output logic [2:0]       ptr,
    output logic [3:0]       count,
    output logic             full
);

    logic [WIDTH-1:0] data_q [8];
    logic [WIDTH-1:0] data_d [8];
    logic [7:0]       o_valid_q, o_valid_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [3:0]       count_q, count_d;
    logic             full_q, full_d;
    logic [2:0]       tgt;
    logic             accept;

    // Target select, ready and next-state computation. A slot being drained
    // this cycle is reported ready so a refill lands with no bubble.
    always_comb begin
        tgt       = auto ? ptr_q : s;
        in_ready  = ~o_valid_q[tgt] | o_ack[tgt];
        accept    = in_valid & in_ready;

        data_d    = data_q;
        o_valid_d = o_valid_q & ~o_ack;
        ptr_d     = ptr_q;
        if (accept) begin
            data_d[tgt]    = I;
            o_valid_d[tgt] = 1'b1;
            if (auto) begin
                ptr_d = ptr_q + 3'd1;
            end
        end

        count_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_d = count_d + 4'(o_valid_d[i]);
        end
        full_d = &o_valid_d;
    end

    // State registers; reset discards every buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
            o_valid_q <= 8'h00;
            ptr_q     <= 3'd0;
            count_q   <= 4'd0;
            full_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
            o_valid_q <= o_valid_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
        end
    end

    assign o0      = data_q[0];
    assign o1      = data_q[1];
    assign o2      = data_q[2];
    assign o3      = data_q[3];
    assign o4      = data_q[4];
    assign o5      = data_q[5];
    assign o6      = data_q[6];
    assign o7      = data_q[7];
    assign o_valid = o_valid_q;
    assign ptr     = ptr_q;
    assign count   = count_q;
    assign full    = full_q;

endmodule
